// File: rtl/tag_ct_rr_merge.sv
// Round-robin merge of NIN tag/count streams into one registered output entry.
// Optional per-input transfer counters are built when TAG_CT_MERGE_STATS_EN is defined.
module tag_ct_rr_merge #(
  parameter int NIN   = 4,
  parameter int Ntag  = 11,
  parameter int Nct   = 10,
  parameter int Nstat = 16,
  localparam int SW   = (NIN > 1) ? $clog2(NIN) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NIN*Ntag-1:0] in_tag,
  input  logic [NIN*Nct-1:0]  in_ct,
  input  logic [NIN-1:0]      in_v,
  output logic [NIN-1:0]      in_a,
  output logic [Ntag-1:0]     out_tag,
  output logic [Nct-1:0]      out_ct,
  output logic                out_v,
  input  logic                out_a,
  output logic [SW-1:0]       out_src
`ifdef TAG_CT_MERGE_STATS_EN
  ,
  input  logic                stat_clr,
  output logic [NIN*Nstat-1:0] stat_cnt
`endif
);

  if (NIN < 2 || NIN > 16 || Nstat < 1) begin : g_bad_params
    $error("tag_ct_rr_merge: unsupported parameter values");
  end

  logic [SW-1:0]   last;
  logic [SW-1:0]   grant;
  logic            found;
  logic            load;
  logic [Ntag-1:0] sel_tag;
  logic [Nct-1:0]  sel_ct;

  assign load = !out_v || out_a;

  // First valid input strictly after the most recently granted one.
  always_comb begin
    found = 1'b0;
    grant = '0;
    for (int k = 1; k <= NIN; k++) begin
      logic [SW-1:0] idx_w;
      idx_w = SW'((int'(last) + k) % NIN);
      if (!found && in_v[idx_w]) begin
        found = 1'b1;
        grant = idx_w;
      end
    end
  end

  always_comb begin
    sel_tag = '0;
    sel_ct  = '0;
    for (int i = 0; i < NIN; i++) begin
      if (grant == SW'(i)) begin
        sel_tag = in_tag[i*Ntag +: Ntag];
        sel_ct  = in_ct[i*Nct +: Nct];
      end
    end
  end

  always_comb begin
    in_a = '0;
    if (found && load && !reset) begin
      in_a[grant] = 1'b1;
    end
  end

  // Output register refills whenever it is empty or being drained.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_v   <= 1'b0;
      out_tag <= '0;
      out_ct  <= '0;
      out_src <= '0;
      last    <= SW'(NIN - 1);
    end else if (load) begin
      out_v <= found;
      if (found) begin
        out_tag <= sel_tag;
        out_ct  <= sel_ct;
        out_src <= grant;
        last    <= grant;
      end
    end
  end

`ifdef TAG_CT_MERGE_STATS_EN
  logic [NIN-1:0] xfer;

  assign xfer = in_v & in_a;

  // Clear takes precedence over a same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_cnt <= '0;
    end else begin
      for (int i = 0; i < NIN; i++) begin
        if (stat_clr) begin
          stat_cnt[i*Nstat +: Nstat] <= '0;
        end else if (xfer[i]) begin
          stat_cnt[i*Nstat +: Nstat] <= stat_cnt[i*Nstat +: Nstat] + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_tag_ct_rr_merge.sv
// Self-checking bench for tag_ct_rr_merge: directed scenarios then random traffic
// against a transaction-level round-robin model.
module tb_tag_ct_rr_merge;

  localparam int NIN   = 4;
  localparam int NTAG  = 11;
  localparam int NCT   = 10;
  localparam int NSTAT = 4;
  localparam int SW    = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [NIN*NTAG-1:0] in_tag;
  logic [NIN*NCT-1:0]  in_ct;
  logic [NIN-1:0]      in_v;
  logic [NIN-1:0]      in_a;
  logic [NTAG-1:0]     out_tag;
  logic [NCT-1:0]      out_ct;
  logic                out_v;
  logic                out_a;
  logic [SW-1:0]       out_src;
`ifdef TAG_CT_MERGE_STATS_EN
  logic                  stat_clr;
  logic [NIN*NSTAT-1:0]  stat_cnt;
  int                    m_cnt[NIN];
`endif

  tag_ct_rr_merge #(
    .NIN(NIN), .Ntag(NTAG), .Nct(NCT), .Nstat(NSTAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_tag(in_tag),
    .in_ct(in_ct),
    .in_v(in_v),
    .in_a(in_a),
    .out_tag(out_tag),
    .out_ct(out_ct),
    .out_v(out_v),
    .out_a(out_a),
    .out_src(out_src)
`ifdef TAG_CT_MERGE_STATS_EN
    ,
    .stat_clr(stat_clr),
    .stat_cnt(stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: the granted-last index and the one output entry.
  int              m_last;
  logic            m_v;
  logic [NTAG-1:0] m_tag;
  logic [NCT-1:0]  m_ct;
  int              m_src;
  logic [NTAG-1:0] tag_d[NIN];
  logic [NCT-1:0]  ct_d[NIN];
  logic [NIN-1:0]  seen_a;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NIN-1:0] v);
    for (int k = 1; k <= NIN; k++) begin
      int idx;
      idx = (m_last + k) % NIN;
      if (v[idx[SW-1:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_last = NIN - 1;
    m_v    = 1'b0;
    m_tag  = '0;
    m_ct   = '0;
    m_src  = 0;
`ifdef TAG_CT_MERGE_STATS_EN
    for (int i = 0; i < NIN; i++) m_cnt[i] = 0;
`endif
  endtask

  // One clock cycle: drive, check accepts, advance model, check outputs.
  task automatic apply_stimulus(input logic [NIN-1:0] v, input logic oa);
    int             g;
    logic           ld;
    logic [NIN-1:0] one;
    logic [NIN-1:0] exp_a;
    in_v  = v;
    out_a = oa;
    for (int i = 0; i < NIN; i++) begin
      in_tag[i*NTAG +: NTAG] = tag_d[i];
      in_ct[i*NCT +: NCT]    = ct_d[i];
    end
    #1;
    g     = pick(v);
    ld    = !m_v || oa;
    one   = 1;
    exp_a = (g >= 0 && ld) ? (one << g) : '0;
    seen_a = in_a;
    check_output("in_a", in_a, exp_a);
    @(posedge clk);
`ifdef TAG_CT_MERGE_STATS_EN
    for (int i = 0; i < NIN; i++) begin
      if (stat_clr) m_cnt[i] = 0;
      else if (exp_a[i]) m_cnt[i] = (m_cnt[i] + 1) % (1 << NSTAT);
    end
`endif
    if (ld) begin
      m_v = (g >= 0);
      if (g >= 0) begin
        m_tag  = tag_d[g];
        m_ct   = ct_d[g];
        m_src  = g;
        m_last = g;
      end
    end
    @(negedge clk);
    check_output("out_v", out_v, m_v);
    check_output("out_tag", out_tag, m_tag);
    check_output("out_ct", out_ct, m_ct);
    check_output("out_src", out_src, m_src);
`ifdef TAG_CT_MERGE_STATS_EN
    for (int i = 0; i < NIN; i++) begin
      check_output("stat_cnt", stat_cnt[i*NSTAT +: NSTAT], m_cnt[i]);
    end
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_v  = '0;
    #1;
    check_output("reset_out_v", out_v, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [NIN-1:0] rv;
    logic           roa;
    reset  = 1'b1;
    in_v   = '0;
    out_a  = 1'b0;
    in_tag = '0;
    in_ct  = '0;
    seen_a = '0;
`ifdef TAG_CT_MERGE_STATS_EN
    stat_clr = 1'b0;
`endif
    for (int i = 0; i < NIN; i++) begin
      tag_d[i] = '0;
      ct_d[i]  = '0;
    end
    model_reset();

    // Reset state: no accepts even with all inputs valid.
    @(negedge clk);
    in_v  = '1;
    out_a = 1'b1;
    #1;
    check_output("reset_in_a", in_a, 4'b0000);
    check_output("reset_out_v", out_v, 1'b0);
    check_output("reset_out_tag", out_tag, 0);
    check_output("reset_out_ct", out_ct, 0);
    check_output("reset_out_src", out_src, 0);
    @(negedge clk);
    reset = 1'b0;
    in_v  = '0;

    // Single transfer from input 2.
    tag_d[2] = 11'h155;
    ct_d[2]  = 10'd7;
    apply_stimulus(4'b0100, 1'b1);
    check_output("single_grant", seen_a, 4'b0100);
    check_output("single_out_v", out_v, 1'b1);
    check_output("single_out_tag", out_tag, 11'h155);
    check_output("single_out_ct", out_ct, 10'd7);
    check_output("single_out_src", out_src, 2);
    apply_stimulus(4'b0000, 1'b1);
    check_output("single_drain", out_v, 1'b0);
    check_output("single_hold_tag", out_tag, 11'h155);

    // Full contention: strict rotation, no bubbles.
    do_reset();
    for (int i = 0; i < NIN; i++) begin
      tag_d[i] = NTAG'($urandom);
      ct_d[i]  = NCT'($urandom);
    end
    for (int c = 0; c < 8; c++) begin
      logic [NIN-1:0] one;
      one = 1;
      apply_stimulus(4'b1111, 1'b1);
      check_output("contention_grant", seen_a, one << (c % NIN));
      check_output("contention_out_v", out_v, 1'b1);
      tag_d[c % NIN] = NTAG'($urandom);
      ct_d[c % NIN]  = NCT'($urandom);
    end

    // Back-pressure: entry 0x0A3 held while inputs 1 and 3 wait.
    do_reset();
    tag_d[0] = 11'h0A3;
    ct_d[0]  = 10'd0;
    apply_stimulus(4'b0001, 1'b0);
    for (int c = 0; c < 5; c++) begin
      apply_stimulus(4'b1010, 1'b0);
      check_output("bp_in_a", seen_a, 4'b0000);
      check_output("bp_out_tag", out_tag, 11'h0A3);
      check_output("bp_out_v", out_v, 1'b1);
    end
    apply_stimulus(4'b1010, 1'b1);
    check_output("bp_release_grant", seen_a, 4'b0010);
    check_output("bp_release_src", out_src, 1);

    // Skip idle inputs: with last=0, inputs 3 and 0 alternate.
    do_reset();
    apply_stimulus(4'b0001, 1'b1);
    for (int c = 0; c < 4; c++) begin
      apply_stimulus(4'b1001, 1'b1);
      check_output("skip_grant", seen_a, (c % 2 == 0) ? 4'b1000 : 4'b0001);
    end

    // Mid-operation reset discards the pending entry at once.
    apply_stimulus(4'b1111, 1'b0);
    check_output("midrst_pre_out_v", out_v, 1'b1);
    reset = 1'b1;
    #1;
    check_output("midrst_out_v", out_v, 1'b0);
    check_output("midrst_in_a", in_a, 4'b0000);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    apply_stimulus(4'b1111, 1'b1);
    check_output("midrst_first_grant", seen_a, 4'b0001);

`ifdef TAG_CT_MERGE_STATS_EN
    // Counter wrap and clear-beats-increment.
    do_reset();
    for (int c = 0; c < 17; c++) apply_stimulus(4'b0010, 1'b1);
    check_output("stat_wrap", stat_cnt[1*NSTAT +: NSTAT], 1);
    stat_clr = 1'b1;
    apply_stimulus(4'b0010, 1'b1);
    check_output("stat_clr_wins", stat_cnt[1*NSTAT +: NSTAT], 0);
    stat_clr = 1'b0;
`endif

    // Random traffic; a waiting input keeps its valid and data stable.
    do_reset();
    rv     = '0;
    seen_a = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NIN; i++) begin
        if (!(rv[i] && !seen_a[i])) begin
          rv[i]    = ($urandom_range(0, 2) != 0);
          tag_d[i] = NTAG'($urandom);
          ct_d[i]  = ($urandom_range(0, 7) == 0) ? '0 : NCT'($urandom);
        end
      end
      roa = ($urandom_range(0, 3) != 0);
`ifdef TAG_CT_MERGE_STATS_EN
      stat_clr = ($urandom_range(0, 15) == 0);
`endif
      apply_stimulus(rv, roa);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
